// File: rtl/soc_bus.sv
// soc_bus: interconnect between the core data port, the RAM and on-chip MMIO.
// Requests below MMIO_BASE go to RAM with a fixed latency; requests at or above
// it hit the MMIO block, which holds an LED register and an 8N1 UART transmitter.
module soc_bus #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       MEM_LATENCY  = 1,
  parameter logic [ADDR_W-1:0] MMIO_BASE    = 32'h1000_0000,
  parameter int unsigned       LED_W        = 5,
  parameter int unsigned       CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [ADDR_W-1:0]     bus_addr,
  input  logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W/8-1:0]   bus_wstrb,
  output logic                  bus_ready,
  output logic [DATA_W-1:0]     bus_rdata,
  output logic                  bus_err,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic                  mem_we,
  output logic                  mem_r_enable,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [LED_W-1:0]      leds,
  output logic                  txd
);

  localparam int unsigned STRB_W    = DATA_W / 8;
  // Latency counter must reach MEM_LATENCY+1.
  localparam int unsigned LAT_W     = $clog2(MEM_LATENCY + 2);
  localparam int unsigned BIT_CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_WAIT,
    S_MMIO
  } state_e;

  state_e                 state_q;
  logic                   we_q;
  logic [LAT_W-1:0]       lat_cnt_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic [STRB_W-1:0]      mem_wstrb_q;
  logic                   mem_we_q;
  logic                   mem_re_q;
  logic                   bus_ready_q;
  logic                   bus_err_q;
  logic [DATA_W-1:0]      bus_rdata_q;
  logic [LED_W-1:0]       leds_q;

  // UART state: frame_q shifts right, its LSB is the line level.
  logic                   tx_busy_q;
  logic [9:0]             frame_q;
  logic [3:0]             bit_idx_q;
  logic [BIT_CNT_W-1:0]   clk_cnt_q;

  // MMIO decode works on the latched address; the two byte-offset bits are ignored.
  logic [ADDR_W-1:0]      mmio_off_d;
  logic [ADDR_W-3:0]      mmio_word_d;
  logic                   sel_led_d;
  logic                   sel_tx_d;
  logic                   sel_stat_d;
  logic                   unused_off_bits;

  assign mmio_off_d      = mem_addr_q - MMIO_BASE;
  assign mmio_word_d     = mmio_off_d[ADDR_W-1:2];
  assign sel_led_d       = (mmio_word_d == (ADDR_W-2)'(0));
  assign sel_tx_d        = (mmio_word_d == (ADDR_W-2)'(1));
  assign sel_stat_d      = (mmio_word_d == (ADDR_W-2)'(2));
  assign unused_off_bits = ^mmio_off_d[1:0];

  // A TX write may load the UART when it is idle or on the final stop-bit
  // cycle, so back-to-back frames follow each other with no idle gap.
  logic tx_last_d;
  logic tx_wr_d;
  logic tx_stall_d;
  logic tx_load_d;

  assign tx_last_d  = tx_busy_q && (bit_idx_q == 4'd9) &&
                      (clk_cnt_q == BIT_CNT_W'(CLKS_PER_BIT - 1));
  assign tx_wr_d    = (state_q == S_MMIO) && we_q && sel_tx_d && mem_wstrb_q[0];
  assign tx_stall_d = tx_wr_d && tx_busy_q && !tx_last_d;
  assign tx_load_d  = tx_wr_d && !tx_stall_d;

  // Request FSM: accept, sequence RAM latency or perform the MMIO access, respond.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      lat_cnt_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      bus_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_rdata_q <= '0;
      leds_q      <= '0;
    end else begin
      bus_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_req) begin
            mem_addr_q  <= bus_addr;
            mem_wdata_q <= bus_wdata;
            mem_wstrb_q <= bus_wstrb;
            we_q        <= bus_we;
            lat_cnt_q   <= '0;
            if (bus_addr >= MMIO_BASE) begin
              state_q <= S_MMIO;
            end else begin
              mem_we_q <= bus_we;
              mem_re_q <= !bus_we;
              state_q  <= S_MEM_WAIT;
            end
          end
        end
        S_MEM_WAIT: begin
          if (lat_cnt_q == LAT_W'(MEM_LATENCY + 1)) begin
            bus_ready_q <= 1'b1;
            bus_rdata_q <= we_q ? '0 : mem_rdata;
            state_q     <= S_IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        S_MMIO: begin
          if (!tx_stall_d) begin
            bus_ready_q <= 1'b1;
            state_q     <= S_IDLE;
            if (sel_led_d) begin
              if (we_q && mem_wstrb_q[0]) begin
                leds_q <= mem_wdata_q[LED_W-1:0];
              end else if (!we_q) begin
                bus_rdata_q <= DATA_W'(leds_q);
              end
            end else if (sel_stat_d) begin
              if (!we_q) begin
                bus_rdata_q <= {{(DATA_W-1){1'b0}}, tx_busy_q};
              end
            end else if (!sel_tx_d) begin
              bus_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // UART transmitter: start bit, 8 data bits LSB first, stop bit; a load always wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_busy_q <= 1'b0;
      frame_q   <= '1;
      bit_idx_q <= '0;
      clk_cnt_q <= '0;
    end else if (tx_load_d) begin
      tx_busy_q <= 1'b1;
      frame_q   <= {1'b1, mem_wdata_q[7:0], 1'b0};
      bit_idx_q <= '0;
      clk_cnt_q <= '0;
    end else if (tx_busy_q) begin
      if (clk_cnt_q == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
        clk_cnt_q <= '0;
        if (bit_idx_q == 4'd9) begin
          tx_busy_q <= 1'b0;
        end else begin
          bit_idx_q <= bit_idx_q + 4'd1;
          frame_q   <= {1'b1, frame_q[9:1]};
        end
      end else begin
        clk_cnt_q <= clk_cnt_q + BIT_CNT_W'(1);
      end
    end
  end

  assign bus_ready    = bus_ready_q;
  assign bus_rdata    = bus_rdata_q;
  assign bus_err      = bus_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign mem_we       = mem_we_q;
  assign mem_r_enable = mem_re_q;
  assign leds         = leds_q;
  assign txd          = frame_q[0];

endmodule

// File: tb/tb_soc_bus.sv
// tb_soc_bus: scoreboard bench for soc_bus with a behavioural RAM device,
// a transaction-level reference model and a bit-level UART line model.
module tb_soc_bus;

  localparam int          MEM_LAT = 1;
  localparam int          CPB     = 4;
  localparam logic [31:0] BASE    = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_wstrb = '0;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_we;
  logic        mem_r_enable;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  leds;
  logic        txd;

  soc_bus #(
    .DATA_W(32), .ADDR_W(32), .MEM_LATENCY(MEM_LAT), .MMIO_BASE(BASE),
    .LED_W(5), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_we(mem_we), .mem_r_enable(mem_r_enable), .mem_rdata(mem_rdata),
    .leds(leds), .txd(txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Edge counter and sampled RAM strobe totals (sole writer: this block).
  int cyc = 0;
  int we_total = 0;
  int re_total = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset_n && mem_we === 1'b1) we_total = we_total + 1;
    if (reset_n && mem_r_enable === 1'b1) re_total = re_total + 1;
  end

  // Behavioural RAM device: registered read, contents hold until the next read.
  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic        ram_load = 1'b1;
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_we === 1'b1)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_r_enable === 1'b1) mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  // Reference model state.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          ready_edge;
    logic [4:0]  leds;
    int          we_n;
    int          re_n;
    logic        chk_addr;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    int         load;
    logic [7:0] data;
  } frame_t;

  exp_t        sb_q[$];
  frame_t      frames[$];
  logic [31:0] ref_mem [0:255];
  logic [4:0]  leds_m  = '0;
  int          tx_free = 0;
  logic        txd_chk_en = 1'b0;

  // Expected line level after edge t, from the list of scheduled frames.
  function automatic logic exp_txd(input int t);
    int b;
    foreach (frames[i]) begin
      if (t >= frames[i].load && t < frames[i].load + 10 * CPB) begin
        b = (t - frames[i].load) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return frames[i].data[b-1];
      end
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (txd_chk_en && reset_n) check("txd", 32'(txd), 32'(exp_txd(cyc)));
  end

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  int we_base = 0;
  int re_base = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      we_base = we_total;
      re_base = re_total;
    end else if (bus_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 32'(bus_ready), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rdata", bus_rdata, e.rdata);
        check("err", 32'(bus_err), 32'(e.err));
        check("ready_cycle", 32'(cyc), 32'(e.ready_edge));
        check("leds", 32'(leds), 32'(e.leds));
        check("mem_we_pulses", 32'(we_total - we_base), 32'(e.we_n));
        check("mem_re_pulses", 32'(re_total - re_base), 32'(e.re_n));
        if (e.chk_addr) check("mem_addr", mem_addr, e.addr);
        $display("txn %0d: addr=%h rdata=%h err=%0d at cycle %0d", n_checks, e.addr, bus_rdata, bus_err, cyc);
        we_base = we_total;
        re_base = re_total;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: predicts the response, pushes it, then holds the request until ready.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
    exp_t        e;
    frame_t      fr;
    int          a;
    int          ld;
    logic [31:0] word;
    logic        got;
    a            = cyc + 1;
    e.rdata      = '0;
    e.err        = 1'b0;
    e.ready_edge = a + 1;
    e.we_n       = 0;
    e.re_n       = 0;
    e.chk_addr   = 1'b0;
    e.addr       = addr;
    if (addr < BASE) begin
      e.ready_edge = a + MEM_LAT + 2;
      e.chk_addr   = 1'b1;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
        e.we_n = 1;
      end else begin
        e.rdata = ref_mem[addr[9:2]];
        e.re_n  = 1;
      end
    end else begin
      word = (addr - BASE) >> 2;
      if (word == 0) begin
        if (we && strb[0]) leds_m = wdata[4:0];
        if (!we) e.rdata = {27'd0, leds_m};
      end else if (word == 1) begin
        if (we && strb[0]) begin
          ld           = (a + 1 > tx_free) ? a + 1 : tx_free;
          e.ready_edge = ld;
          fr.load      = ld;
          fr.data      = wdata[7:0];
          frames.push_back(fr);
          tx_free      = ld + 10 * CPB;
        end
      end else if (word == 2) begin
        if (!we) e.rdata = (a < tx_free) ? 32'd1 : 32'd0;
      end else begin
        e.err = 1'b1;
      end
    end
    e.leds = leds_m;
    sb_q.push_back(e);
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_wstrb = strb;
    got       = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      tick();
      if (bus_ready === 1'b1) got = 1'b1;
    end
    bus_req = 1'b0;
    bus_we  = 1'b0;
    if (!got) begin
      check("ready_timeout", 32'(got), 32'd1);
      sb_q.delete();
    end
    tick();
  endtask

  initial begin
    logic [31:0] addr;
    int          r;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // Reset state.
    tick();
    ram_load = 1'b0;
    tick();
    check("rst_ready", 32'(bus_ready), 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_r_enable), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_txd", 32'(txd), 32'd1);
    reset_n    = 1'b1;
    txd_chk_en = 1'b1;
    tick();

    // RAM write/read with full and partial strobes.
    do_txn(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    do_txn(1'b0, 32'h40, 32'h0, 4'h0);
    do_txn(1'b1, 32'h44, 32'h1234_5678, 4'b0011);
    do_txn(1'b0, 32'h44, 32'h0, 4'h0);

    // LED register, including a strobe-less write.
    do_txn(1'b1, BASE, 32'h15, 4'h1);
    do_txn(1'b0, BASE, 32'h0, 4'h0);
    do_txn(1'b1, BASE, 32'h0A, 4'h0);
    do_txn(1'b0, BASE + 32'd2, 32'h0, 4'h0);

    // One UART frame with STAT polling across it.
    do_txn(1'b1, BASE + 32'd4, 32'hA5, 4'h1);
    for (int k = 0; k < 16; k++) do_txn(1'b0, BASE + 32'd8, 32'h0, 4'h0);

    // Back-to-back frames: the second write stalls until the first ends.
    do_txn(1'b1, BASE + 32'd4, 32'h5A, 4'h1);
    do_txn(1'b1, BASE + 32'd4, 32'hC3, 4'h1);
    do_txn(1'b0, BASE + 32'd4, 32'h0, 4'h0);

    // Unmapped offsets.
    do_txn(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    do_txn(1'b1, BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF);
    repeat (90) tick();

    // Reset while a frame runs and a second TX write is stalled.
    do_txn(1'b1, BASE + 32'd4, 32'h3C, 4'h1);
    repeat (8) tick();
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = BASE + 32'd4;
    bus_wdata = 32'h77;
    bus_wstrb = 4'h1;
    repeat (4) tick();
    reset_n = 1'b0;
    bus_req = 1'b0;
    bus_we  = 1'b0;
    frames.delete();
    tx_free = 0;
    leds_m  = '0;
    tick();
    tick();
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_leds", 32'(leds), 32'd0);
    check("midrst_ready", 32'(bus_ready), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_ready", 32'(bus_ready), 32'd0);
    end

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: do_txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom, 4'($urandom_range(0, 15)));
        4, 5:       do_txn(1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
        6:          do_txn(1'($urandom_range(0, 1)), BASE + 32'd8 + 32'($urandom_range(0, 3)), $urandom, 4'hF);
        7:          do_txn(1'($urandom_range(0, 3) != 0), BASE + 32'd4, $urandom, 4'($urandom_range(0, 15)));
        8: begin
          addr = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 : BASE + (32'($urandom_range(3, 4000)) << 2) + 32'($urandom_range(0, 3));
          do_txn(1'($urandom_range(0, 1)), addr, $urandom, 4'hF);
        end
        default:    do_txn(1'($urandom_range(0, 1)), 32'h0FFF_FFFC + 32'($urandom_range(0, 3)), $urandom, 4'hF);
      endcase
    end
    repeat (10 * CPB + 5) tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
